// File: rtl/riscv_div_issue_ctrl.sv
// Issue/stall controller between execute and the 64-iteration riscv_divider.
// Optional 1-entry result cache: define RISCV_DIV_RESULT_CACHE_EN.
module riscv_div_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             i_riscv_div_clk,
    input  logic             i_riscv_div_rst,
    input  logic             i_riscv_divctl_req,
    input  logic [3:0]       i_riscv_divctl_ctrl,
    input  logic [XLEN-1:0]  i_riscv_divctl_rs1,
    input  logic [XLEN-1:0]  i_riscv_divctl_rs2,
    input  logic [TAG_W-1:0] i_riscv_divctl_rd,
    input  logic             i_riscv_divctl_flush,
    output logic             o_riscv_divctl_stall,
    output logic             o_riscv_divctl_done,
    output logic [XLEN-1:0]  o_riscv_divctl_result,
    output logic [TAG_W-1:0] o_riscv_divctl_rd,
    output logic [3:0]       o_riscv_divctl_divctrl,
    output logic [XLEN-1:0]  o_riscv_divctl_rs1data,
    output logic [XLEN-1:0]  o_riscv_divctl_rs2data,
    input  logic [XLEN-1:0]  i_riscv_divctl_div_result,
    input  logic             i_riscv_divctl_div_valid
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t           state_q;
    logic [3:0]       ctrl_q;
    logic [3:0]       divctrl_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] rd_q;
    logic             done_q;

    logic             accept;
    logic             hit;
    logic [XLEN-1:0]  hit_result;

    // done_q keeps the instruction that is retiring this cycle from being re-issued.
    assign accept = (state_q == IDLE) & i_riscv_divctl_req & i_riscv_divctl_ctrl[3]
                  & ~i_riscv_divctl_flush & ~done_q;

`ifdef RISCV_DIV_RESULT_CACHE_EN
    logic [3:0]      cache_ctrl_q;
    logic [XLEN-1:0] cache_rs1_q;
    logic [XLEN-1:0] cache_rs2_q;
    logic [XLEN-1:0] cache_res_q;
    logic            cache_vld_q;

    assign hit = cache_vld_q & (cache_ctrl_q == i_riscv_divctl_ctrl)
               & (cache_rs1_q == i_riscv_divctl_rs1) & (cache_rs2_q == i_riscv_divctl_rs2);
    assign hit_result = cache_res_q;

    always_ff @(posedge i_riscv_div_clk or posedge i_riscv_div_rst) begin
        if (i_riscv_div_rst) begin
            cache_ctrl_q <= '0;
            cache_rs1_q  <= '0;
            cache_rs2_q  <= '0;
            cache_res_q  <= '0;
            cache_vld_q  <= 1'b0;
        end else if ((state_q == BUSY) && i_riscv_divctl_div_valid && !i_riscv_divctl_flush) begin
            cache_ctrl_q <= ctrl_q;
            cache_rs1_q  <= rs1_q;
            cache_rs2_q  <= rs2_q;
            cache_res_q  <= i_riscv_divctl_div_result;
            cache_vld_q  <= 1'b1;
        end
    end
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    always_ff @(posedge i_riscv_div_clk or posedge i_riscv_div_rst) begin
        if (i_riscv_div_rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            divctrl_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && hit) begin
                        done_q   <= 1'b1;
                        result_q <= hit_result;
                        rd_q     <= i_riscv_divctl_rd;
                    end else if (accept) begin
                        ctrl_q    <= i_riscv_divctl_ctrl;
                        divctrl_q <= i_riscv_divctl_ctrl;
                        rs1_q     <= i_riscv_divctl_rs1;
                        rs2_q     <= i_riscv_divctl_rs2;
                        tag_q     <= i_riscv_divctl_rd;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    // A flush coinciding with div_valid still returns to IDLE: the divider has finished.
                    if (i_riscv_divctl_div_valid) begin
                        divctrl_q <= '0;
                        state_q   <= IDLE;
                        if (!i_riscv_divctl_flush) begin
                            done_q   <= 1'b1;
                            result_q <= i_riscv_divctl_div_result;
                            rd_q     <= tag_q;
                        end
                    end else if (i_riscv_divctl_flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_riscv_divctl_div_valid) begin
                        divctrl_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_riscv_divctl_stall   = accept | (state_q == BUSY)
                                  | ((state_q == DRAIN) & i_riscv_divctl_req);
    assign o_riscv_divctl_done    = done_q;
    assign o_riscv_divctl_result  = result_q;
    assign o_riscv_divctl_rd      = rd_q;
    assign o_riscv_divctl_divctrl = divctrl_q;
    assign o_riscv_divctl_rs1data = rs1_q;
    assign o_riscv_divctl_rs2data = rs2_q;

endmodule

// File: tb/tb_riscv_div_issue_ctrl.sv
// Scoreboard bench for riscv_div_issue_ctrl with a behavioural 64-iteration divider.
module tb_riscv_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  ctrl = '0;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        stall, done;
    logic [63:0] result;
    logic [4:0]  rd_o;
    logic [3:0]  divctrl;
    logic [63:0] rs1data, rs2data;
    logic [63:0] div_result;
    logic        div_valid;

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned cyc;
        logic [63:0] res;
        logic [4:0]  rd;
    } exp_t;
    exp_t sbq[$];

    logic [3:0]  mc_c = '0;
    logic [63:0] mc_a = '0, mc_b = '0, mc_r = '0;
    bit          mc_v = 0;

    riscv_div_issue_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .i_riscv_div_clk          (clk),
        .i_riscv_div_rst          (rst),
        .i_riscv_divctl_req       (req),
        .i_riscv_divctl_ctrl      (ctrl),
        .i_riscv_divctl_rs1       (rs1),
        .i_riscv_divctl_rs2       (rs2),
        .i_riscv_divctl_rd        (rd),
        .i_riscv_divctl_flush     (flush),
        .o_riscv_divctl_stall     (stall),
        .o_riscv_divctl_done      (done),
        .o_riscv_divctl_result    (result),
        .o_riscv_divctl_rd        (rd_o),
        .o_riscv_divctl_divctrl   (divctrl),
        .o_riscv_divctl_rs1data   (rs1data),
        .o_riscv_divctl_rs2data   (rs2data),
        .i_riscv_divctl_div_result(div_result),
        .i_riscv_divctl_div_valid (div_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M-extension division; ctrl = {start, not_word, rem, unsigned}.
    function automatic logic [63:0] ref_div(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [31:0] q;
        logic [63:0] r;
        if (c[2]) begin
            sa = a; sb = b;
            if (b == 0)                                  r = c[1] ? a : '1;
            else if (c[0])                               r = c[1] ? a % b : a / b;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = c[1] ? 64'd0 : a;
            else                                         r = c[1] ? 64'(sa % sb) : 64'(sa / sb);
        end else begin
            wa = a[31:0]; wb = b[31:0];
            if (b[31:0] == 0)                            q = c[1] ? a[31:0] : '1;
            else if (c[0])                               q = c[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
            else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) q = c[1] ? 32'd0 : a[31:0];
            else                                         q = c[1] ? 32'(wa % wb) : 32'(wa / wb);
            r = {{32{q[31]}}, q};
        end
        return r;
    endfunction

    function automatic bit model_hit(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
`ifdef RISCV_DIV_RESULT_CACHE_EN
        return mc_v && mc_c == c && mc_a == a && mc_b == b;
`else
        return 1'b0;
`endif
    endfunction

    // Divider: start seen at a cycle, valid pulses 65 cycles later; inputs must stay put meanwhile.
    logic        dv_busy;
    int          dv_n;
    logic [3:0]  dv_c;
    logic [63:0] dv_a, dv_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_busy    <= 1'b0;
            dv_n       <= 0;
            div_valid  <= 1'b0;
            div_result <= '0;
            dv_c <= '0; dv_a <= '0; dv_b <= '0;
        end else begin
            if (div_valid) div_valid <= 1'b0;
            if (!dv_busy && divctrl[3] && !div_valid) begin
                dv_busy <= 1'b1;
                dv_n    <= 0;
                dv_c <= divctrl; dv_a <= rs1data; dv_b <= rs2data;
            end else if (dv_busy) begin
                chk("div_inputs_stable", {divctrl, rs1data[59:0]} ^ rs2data, {dv_c, dv_a[59:0]} ^ dv_b);
                if (dv_n == 63) begin
                    div_valid  <= 1'b1;
                    div_result <= ref_div(dv_c, dv_a, dv_b);
                    dv_busy    <= 1'b0;
                end
                dv_n <= dv_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %h rd %0d want no done (cycle %0d)", result, rd_o, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("result", result, e.res);
                chk("rd_tag", 64'(rd_o), 64'(e.rd));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] t, input logic [63:0] want);
        int unsigned t0;
        bit h;
        exp_t e;
        @(negedge clk);
        req = 1'b1; ctrl = c; rs1 = a; rs2 = b; rd = t;
        #1;
        t0 = cyc;
        h = model_hit(c, a, b);
        chk("stall_accept", 64'(stall), 64'd1);
        e.cyc = h ? t0 + 1 : t0 + 67;
        e.res = h ? mc_r : want;
        e.rd  = t;
        sbq.push_back(e);
        @(negedge clk);
        req = 1'b0; ctrl = 4'($urandom); rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom}; rd = 5'($urandom);
        if (h) begin
            #1;
            chk("stall_hit_release", 64'(stall), 64'd0);
            chk("divctrl_hit_idle", 64'(divctrl), 64'd0);
        end else begin
            for (int k = 1; k <= 67; k++) begin
                #1;
                chk("stall_busy", 64'(stall), 64'(k <= 66));
                if (k == 1)  chk("divctrl_start", 64'(divctrl), 64'(c));
                if (k == 67) chk("divctrl_clear", 64'(divctrl), 64'd0);
                if (k < 67) @(negedge clk);
            end
        end
        mc_c = c; mc_a = a; mc_b = b; mc_r = e.res; mc_v = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned t0;
        exp_t e;
        wait_cycles(3);
        #1;
        chk("rst_divctrl", 64'(divctrl), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_rd", 64'(rd_o), 64'd0);
        rst = 1'b0;

        run_op(4'b1100, 64'd100, 64'd7, 5'd11, 64'd14);
        run_op(4'b1100, 64'd100, 64'd7, 5'd12, 64'd14);
        run_op(4'b1110, -64'sd100, 64'd7, 5'd13, -64'sd2);
        run_op(4'b1000, 64'hFFFF_FFFF_8000_0000, '1, 5'd14, 64'hFFFF_FFFF_8000_0000);

        // Request without the start bit is ignored.
        @(negedge clk);
        req = 1'b1; ctrl = 4'b0100; rs1 = 64'd5; rs2 = 64'd3;
        #1 chk("nostart_stall", 64'(stall), 64'd0);
        wait_cycles(3);
        #1 chk("nostart_divctrl", 64'(divctrl), 64'd0);
        req = 1'b0;

        // Back-to-back: second request held at the done cycle must not be taken until next cycle.
        run_op(4'b1100, 64'd9, 64'd2, 5'd1, 64'd4);
        req = 1'b1; ctrl = 4'b1110; rs1 = 64'd9; rs2 = 64'd2; rd = 5'd2;
        #1 chk("stall_doneq_block", 64'(stall), 64'd0);
        run_op(4'b1110, 64'd9, 64'd2, 5'd2, 64'd1);

        // Flush mid-operation, then a request held through the drain.
        @(negedge clk);
        req = 1'b1; ctrl = 4'b1101; rs1 = 64'd50; rs2 = 64'd5; rd = 5'd3;
        #1 t0 = cyc;
        chk("flush_accept_stall", 64'(stall), 64'd1);
        @(negedge clk);
        req = 1'b0;
        while (cyc < t0 + 20) @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_busy_stall", 64'(stall), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        req = 1'b1; ctrl = 4'b1111; rs1 = 64'd50; rs2 = 64'd7; rd = 5'd4;
        for (int k = 21; k <= 66; k++) begin
            #1 chk("drain_stall", 64'(stall), 64'd1);
            @(negedge clk);
        end
        #1 chk("post_drain_accept", 64'(stall), 64'd1);
        e.cyc = t0 + 67 + 67; e.res = 64'd1; e.rd = 5'd4;
        sbq.push_back(e);
        @(negedge clk);
        req = 1'b0;
        while (cyc < t0 + 136) @(negedge clk);
        mc_c = 4'b1111; mc_a = 64'd50; mc_b = 64'd7; mc_r = 64'd1; mc_v = 1;

        run_op(4'b1101, 64'd1234, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 10; i++) begin
            logic [3:0]  c;
            logic [63:0] a, b;
            int sel;
            c = {1'b1, 3'($urandom)};
            a = {$urandom, $urandom};
            sel = $urandom_range(0, 4);
            b = (sel == 0) ? 64'd0 : (sel == 1) ? '1 :
                (sel == 2) ? 64'($urandom_range(1, 100)) : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = (c[2]) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            run_op(c, a, b, 5'($urandom), ref_div(c, a, b));
            wait_cycles($urandom_range(0, 3));
        end

        // Reset in the middle of a run: nothing retires, everything back to zero.
        @(negedge clk);
        req = 1'b1; ctrl = 4'b1101; rs1 = 64'd77; rs2 = 64'd0; rd = 5'd9;
        #1 t0 = cyc;
        @(negedge clk);
        req = 1'b0;
        while (cyc < t0 + 30) @(negedge clk);
        rst = 1'b1;
        mc_v = 0;
        #1;
        chk("midrst_divctrl", 64'(divctrl), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_rd", 64'(rd_o), 64'd0);
        chk("midrst_rs1", rs1data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(80);

        run_op(4'b1100, 64'd100, 64'd7, 5'd21, 64'd14);
        wait_cycles(2);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
